// File: rtl/scene_switcher.sv
// -----------------------------------------------------------------------------
// scene_switcher
//
// Selects one of N_SCENES VGA scene streams (RGB + vs + hs) and presents it as
// a single registered stream for the VGA output stage. Scene changes requested
// by the game-state controller only take effect on a frame boundary of the
// scene currently on screen, so the output never shows a torn frame or a
// broken sync pulse.
//
// Optional feature, enabled by defining SCENE_SWITCHER_FADE_EN:
//   A scene change becomes a frame-stepped fade-to-black of the old scene,
//   a swap while fully black, then a frame-stepped fade-in of the new scene.
//   Without the macro the swap is instant at the first frame edge and no
//   scaling logic is built.
//
// Ports:
//   i_pclk       pixel clock
//   i_rst        asynchronous, active-low reset
//   i_sel        requested scene index (out-of-range values are ignored)
//   i_scene_rgb  scene k RGB at [k*3*CH_W +: 3*CH_W], R,G,B MSB first
//   i_scene_vs   scene k vertical sync at bit k
//   i_scene_hs   scene k horizontal sync at bit k
//   o_rgb        selected (and, with fading, scaled) RGB, 2-cycle latency
//   o_vs         selected vs, same 2-cycle latency, never faded
//   o_hs         selected hs, same 2-cycle latency, never faded
//   o_cur_sel    scene currently routed to the output
//   o_busy       request pending or transition in progress
// -----------------------------------------------------------------------------
module scene_switcher #(
   parameter int N_SCENES  = 3,
   parameter int SEL_W     = 2,
   parameter int CH_W      = 4,
   parameter int LEVEL_W   = 3,
   parameter int VS_POL    = 0,
   parameter int RESET_SEL = 0
) (
   input  logic                         i_pclk,
   input  logic                         i_rst,
   input  logic [SEL_W-1:0]             i_sel,
   input  logic [N_SCENES*3*CH_W-1:0]   i_scene_rgb,
   input  logic [N_SCENES-1:0]          i_scene_vs,
   input  logic [N_SCENES-1:0]          i_scene_hs,
   output logic [3*CH_W-1:0]            o_rgb,
   output logic                         o_vs,
   output logic                         o_hs,
   output logic [SEL_W-1:0]             o_cur_sel,
   output logic                         o_busy
);

   localparam int               RGB_W   = 3 * CH_W;
   localparam logic             VS_ACT  = 1'(VS_POL);
   localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(RESET_SEL);

   logic [SEL_W-1:0] cur_sel;
   logic [SEL_W-1:0] cur_sel_next;
   logic [RGB_W-1:0] sel_rgb;
   logic             sel_vs;
   logic             sel_hs;
   logic             next_vs;
   logic             prev_vs;
   logic             frame_edge;
   logic             in_range;
   logic             valid_req;
   logic             busy;
   logic             busy_next;
   logic [RGB_W-1:0] s1_rgb;
   logic             s1_vs;
   logic             s1_hs;
   logic [RGB_W-1:0] scaled_rgb;

   // Raw stream of the scene currently on screen; feeds both stage 1 and the
   // frame-edge detector.
   always_comb begin
      sel_rgb = '0;
      sel_vs  = 1'b0;
      sel_hs  = 1'b0;
      for (int k = 0; k < N_SCENES; k++) begin
         if (cur_sel == SEL_W'(k)) begin
            sel_rgb = i_scene_rgb[k*RGB_W +: RGB_W];
            sel_vs  = i_scene_vs[k];
            sel_hs  = i_scene_hs[k];
         end
      end
   end

   // The edge detector's history is always loaded from the scene that will be
   // on screen next cycle, so a swap compares the new scene against itself and
   // cannot produce a false frame edge.
   always_comb begin
      next_vs = 1'b0;
      for (int k = 0; k < N_SCENES; k++) begin
         if (cur_sel_next == SEL_W'(k)) begin
            next_vs = i_scene_vs[k];
         end
      end
   end

   assign frame_edge = (prev_vs != VS_ACT) && (sel_vs == VS_ACT);
   assign in_range   = 32'(i_sel) < 32'(N_SCENES);
   assign valid_req  = in_range && (i_sel != cur_sel);

`ifdef SCENE_SWITCHER_FADE_EN

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      FADE_IN
   } state_t;

   localparam logic [LEVEL_W:0] LEVEL_FULL = {1'b1, {LEVEL_W{1'b0}}};
   localparam logic [LEVEL_W:0] LEVEL_ONE  = (LEVEL_W+1)'(1);

   state_t           state;
   state_t           state_next;
   logic [SEL_W-1:0] target;
   logic [SEL_W-1:0] target_next;
   logic [LEVEL_W:0] level;
   logic [LEVEL_W:0] level_next;

   always_ff @(posedge i_pclk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= IDLE;
         target <= SEL_RST;
         level  <= LEVEL_FULL;
      end else begin
         state  <= state_next;
         target <= target_next;
         level  <= level_next;
      end
   end

   // Fade sequencing. In FADE_OUT a request for the scene already on screen
   // cancels the fade (ramp back up without swapping); any other valid request
   // retargets. The swap happens on the first frame edge seen at level 0, so
   // the new scene's first frame is black.
   always_comb begin
      state_next   = state;
      target_next  = target;
      level_next   = level;
      cur_sel_next = cur_sel;
      case (state)
         IDLE: begin
            if (frame_edge && valid_req) begin
               target_next = i_sel;
               state_next  = FADE_OUT;
            end
         end
         FADE_OUT: begin
            if (i_sel == cur_sel) begin
               state_next = FADE_IN;
            end else begin
               if (valid_req) begin
                  target_next = i_sel;
               end
               if (frame_edge) begin
                  if (level != '0) begin
                     level_next = level - LEVEL_ONE;
                  end else begin
                     cur_sel_next = target_next;
                     state_next   = FADE_IN;
                  end
               end
            end
         end
         FADE_IN: begin
            // A cancel issued at full level lands here already at full, so
            // saturate rather than overshoot.
            if (frame_edge) begin
               if (level >= LEVEL_FULL - LEVEL_ONE) begin
                  level_next = LEVEL_FULL;
                  state_next = IDLE;
               end else begin
                  level_next = level + LEVEL_ONE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE) || (in_range && (i_sel != cur_sel_next));
   end

   // Each channel is scaled by level / 2^LEVEL_W; at full level the product
   // shifted back down is exactly the input channel.
   always_comb begin
      scaled_rgb = '0;
      for (int c = 0; c < 3; c++) begin
         scaled_rgb[c*CH_W +: CH_W] = CH_W'(
            ((CH_W+LEVEL_W+1)'(s1_rgb[c*CH_W +: CH_W]) *
             (CH_W+LEVEL_W+1)'(level)) >> LEVEL_W);
      end
   end

`else

   // Instant switching: the request is honoured at the first frame edge.
   always_comb begin
      cur_sel_next = cur_sel;
      if (frame_edge && valid_req) begin
         cur_sel_next = i_sel;
      end
      busy_next = in_range && (i_sel != cur_sel_next);
   end

   assign scaled_rgb = s1_rgb;

`endif

   always_ff @(posedge i_pclk or negedge i_rst) begin
      if (!i_rst) begin
         cur_sel <= SEL_RST;
         prev_vs <= VS_ACT;
         busy    <= 1'b0;
      end else begin
         cur_sel <= cur_sel_next;
         prev_vs <= next_vs;
         busy    <= busy_next;
      end
   end

   // Two-stage datapath: stage 1 holds the raw selected stream, stage 2 the
   // scaled RGB with syncs delayed alongside so all three stay aligned.
   always_ff @(posedge i_pclk or negedge i_rst) begin
      if (!i_rst) begin
         s1_rgb <= '0;
         s1_vs  <= 1'b0;
         s1_hs  <= 1'b0;
         o_rgb  <= '0;
         o_vs   <= 1'b0;
         o_hs   <= 1'b0;
      end else begin
         s1_rgb <= sel_rgb;
         s1_vs  <= sel_vs;
         s1_hs  <= sel_hs;
         o_rgb  <= scaled_rgb;
         o_vs   <= s1_vs;
         o_hs   <= s1_hs;
      end
   end

   assign o_cur_sel = cur_sel;
   assign o_busy    = busy;

endmodule

// File: tb/tb_scene_switcher.sv
// -----------------------------------------------------------------------------
// tb_scene_switcher
//
// Drives three free-running scene generators (different frame periods, random
// or fixed pixel data) into scene_switcher and compares every output, every
// cycle, against a frame-level reference model. With SCENE_SWITCHER_FADE_EN
// the model plans a whole transition as a queue of per-frame-edge
// (scene, level) steps; retarget rewrites the queued destination and cancel
// replaces the queue with a ramp back up.
// -----------------------------------------------------------------------------
module tb_scene_switcher;

   localparam int N     = 3;
   localparam int FULL  = 8;

   logic        clk;
   logic        rst_n;
   logic [1:0]  sel;
   logic [35:0] scene_rgb;
   logic [2:0]  scene_vs;
   logic [2:0]  scene_hs;
   logic [11:0] o_rgb;
   logic        o_vs;
   logic        o_hs;
   logic [1:0]  o_cur_sel;
   logic        o_busy;

   scene_switcher #(
      .N_SCENES (3),
      .SEL_W    (2),
      .CH_W     (4),
      .LEVEL_W  (3),
      .VS_POL   (0),
      .RESET_SEL(0)
   ) dut (
      .i_pclk     (clk),
      .i_rst      (rst_n),
      .i_sel      (sel),
      .i_scene_rgb(scene_rgb),
      .i_scene_vs (scene_vs),
      .i_scene_hs (scene_hs),
      .o_rgb      (o_rgb),
      .o_vs       (o_vs),
      .o_hs       (o_hs),
      .o_cur_sel  (o_cur_sel),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // scene generators
   int          period [3] = '{40, 53, 47};
   int          cnt    [3] = '{0, 17, 31};
   bit          use_fixed [3] = '{0, 0, 0};
   logic [11:0] fixed_rgb [3] = '{12'h000, 12'h000, 12'h000};

   // reference model
   typedef struct {
      int s;
      int l;
   } step_t;

   step_t       plan[$];
   int          m_cur;
   int          m_level;
   bit          m_first;
   logic [2:0]  m_prev_vs;
   logic [11:0] m_s1_rgb;
   logic        m_s1_vs;
   logic        m_s1_hs;
   logic [11:0] m_out_rgb;
   logic        m_out_vs;
   logic        m_out_hs;
   logic        m_busy;

   function automatic logic [11:0] scale(input logic [11:0] c, input int l);
      int r;
      int g;
      int b;
      r = int'(c[11:8]) * l / FULL;
      g = int'(c[7:4])  * l / FULL;
      b = int'(c[3:0])  * l / FULL;
      return {r[3:0], g[3:0], b[3:0]};
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("rgb",     32'(o_rgb),     32'(m_out_rgb));
      checkValue("vs",      32'(o_vs),      32'(m_out_vs));
      checkValue("hs",      32'(o_hs),      32'(m_out_hs));
      checkValue("cur_sel", 32'(o_cur_sel), 32'(m_cur));
      checkValue("busy",    32'(o_busy),    32'(m_busy));
   endtask

   task automatic modelReset();
      plan.delete();
      m_cur     = 0;
      m_level   = FULL;
      m_first   = 1;
      m_s1_rgb  = '0;
      m_s1_vs   = 1'b0;
      m_s1_hs   = 1'b0;
      m_out_rgb = '0;
      m_out_vs  = 1'b0;
      m_out_hs  = 1'b0;
      m_busy    = 1'b0;
   endtask

   task automatic modelStep();
      bit edge_now;
      bit valid;
      int s;
      s        = int'(sel);
      edge_now = !m_first && m_prev_vs[m_cur] && !scene_vs[m_cur];
      m_out_rgb = scale(m_s1_rgb, m_level);
      m_out_vs  = m_s1_vs;
      m_out_hs  = m_s1_hs;
      m_s1_rgb  = scene_rgb[m_cur*12 +: 12];
      m_s1_vs   = scene_vs[m_cur];
      m_s1_hs   = scene_hs[m_cur];
      valid     = (s < N) && (s != m_cur);
`ifdef SCENE_SWITCHER_FADE_EN
      if (plan.size() == 0) begin
         if (edge_now && valid) begin
            for (int l = m_level - 1; l >= 0; l--) plan.push_back('{m_cur, l});
            plan.push_back('{s, 0});
            for (int l = 1; l <= FULL; l++) plan.push_back('{s, l});
         end
      end else if (plan[$].s != m_cur) begin
         if (s == m_cur) begin
            plan.delete();
            for (int l = (m_level < FULL ? m_level + 1 : FULL); l <= FULL; l++)
               plan.push_back('{m_cur, l});
         end else begin
            if (valid) begin
               foreach (plan[i]) if (plan[i].s != m_cur) plan[i].s = s;
            end
            if (edge_now) begin
               m_cur   = plan[0].s;
               m_level = plan[0].l;
               void'(plan.pop_front());
            end
         end
      end else if (edge_now) begin
         m_cur   = plan[0].s;
         m_level = plan[0].l;
         void'(plan.pop_front());
      end
      m_busy = (plan.size() != 0) || ((s < N) && (s != m_cur));
`else
      if (edge_now && valid) m_cur = s;
      m_busy = (s < N) && (s != m_cur);
`endif
      m_prev_vs = scene_vs;
      m_first   = 0;
   endtask

   task automatic driveScenes();
      for (int k = 0; k < N; k++) begin
         scene_vs[k] = (cnt[k] < 4) ? 1'b0 : 1'b1;
         scene_hs[k] = ((cnt[k] % 8) < 2) ? 1'b0 : 1'b1;
         scene_rgb[k*12 +: 12] = use_fixed[k] ? fixed_rgb[k] : 12'($urandom);
      end
   endtask

   // One cycle: check outputs on the falling edge, then drive the inputs for
   // the next rising edge and advance the model to match.
   task automatic applyStimulus(input logic [1:0] s, input logic r);
      @(negedge clk);
      checkOutput();
      for (int k = 0; k < N; k++) cnt[k] = (cnt[k] + 1) % period[k];
      driveScenes();
      sel   = s;
      rst_n = r;
      if (r) modelStep();
      else   modelReset();
   endtask

   task automatic waitIdle(input logic [1:0] s, input int budget);
      int n;
      n = 0;
      while ((plan.size() != 0 || m_busy) && n < budget) begin
         applyStimulus(s, 1'b1);
         n++;
      end
      checks++;
      assert (n < budget) else begin
         errors++;
         $error("[TB] FAIL wait_idle: waited %0d cycles, limit %0d", n, budget);
      end
      applyStimulus(s, 1'b1);
   endtask

   task automatic tickToEdge(input logic [1:0] hold);
      int n;
      n = 0;
      while (((cnt[m_cur] + 1) % period[m_cur]) != 0 && n < 200) begin
         applyStimulus(hold, 1'b1);
         n++;
      end
   endtask

   task automatic waitLevel(input logic [1:0] s, input int lvl, input bit fade_in, input int budget);
      int n;
      n = 0;
      while (!(plan.size() != 0 && m_level == lvl && ((plan[$].s == m_cur) == fade_in)) && n < budget) begin
         applyStimulus(s, 1'b1);
         n++;
      end
      checks++;
      assert (n < budget) else begin
         errors++;
         $error("[TB] FAIL wait_level: level %0d not reached in %0d cycles", lvl, budget);
      end
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] orig;
      int         hold;
      rst_n = 1'b0;
      sel   = 2'd0;
`ifdef SCENE_SWITCHER_FADE_EN
      use_fixed[0] = 1;
      fixed_rgb[0] = 12'hF84;
`endif
      driveScenes();
      modelReset();
      m_prev_vs = scene_vs;
      $display("[TB] reset with random inputs");
      repeat (6) applyStimulus(2'($urandom_range(0, 3)), 1'b0);

      $display("[TB] release reset, scene 0 passthrough");
      applyStimulus(2'd0, 1'b1);
      repeat (60) applyStimulus(2'd0, 1'b1);

      $display("[TB] switch 0 -> 2 mid-frame");
      applyStimulus(2'd2, 1'b1);
      waitIdle(2'd2, 2500);
      checkValue("switch_to_2", 32'(o_cur_sel), 32'd2);

      $display("[TB] out-of-range select ignored");
      repeat (180) applyStimulus(2'd3, 1'b1);

      $display("[TB] request coincident with frame edge");
      tickToEdge(2'd2);
      applyStimulus(2'd1, 1'b1);
      waitIdle(2'd1, 2500);
      checkValue("edge_request_to_1", 32'(o_cur_sel), 32'd1);

      $display("[TB] random requests");
      for (int i = 0; i < 8; i++) begin
         a    = 2'($urandom_range(0, 3));
         hold = int'($urandom_range(20, 400));
         repeat (hold) applyStimulus(a, 1'b1);
      end
      waitIdle(a, 2500);

`ifdef SCENE_SWITCHER_FADE_EN
      $display("[TB] retarget during fade-out");
      orig = 2'(m_cur);
      a    = 2'((m_cur + 1) % N);
      b    = 2'((m_cur + 2) % N);
      applyStimulus(a, 1'b1);
      waitLevel(a, 6, 1'b0, 2500);
      applyStimulus(b, 1'b1);
      waitIdle(b, 2500);
      checkValue("retarget_dest", 32'(o_cur_sel), 32'(b));

      $display("[TB] cancel during fade-out");
      orig = b;
      a    = 2'((int'(b) + 1) % N);
      applyStimulus(a, 1'b1);
      waitLevel(a, 4, 1'b0, 2500);
      applyStimulus(orig, 1'b1);
      waitIdle(orig, 2500);
      checkValue("cancel_no_swap", 32'(o_cur_sel), 32'(orig));
`endif

      $display("[TB] asynchronous reset during a transition");
      a = 2'((m_cur + 1) % N);
      applyStimulus(a, 1'b1);
`ifdef SCENE_SWITCHER_FADE_EN
      waitLevel(a, 2, 1'b1, 2500);
`else
      repeat (5) applyStimulus(a, 1'b1);
`endif
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput();
      checkValue("async_rst_rgb", 32'(o_rgb), 32'd0);
      repeat (3) applyStimulus(2'd0, 1'b0);
      applyStimulus(2'd0, 1'b1);
      repeat (80) applyStimulus(2'd0, 1'b1);
      checkValue("post_reset_sel", 32'(o_cur_sel), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
